// File: rtl/match_result_tx_if.sv
// Byte-wide valid/ready link from the result packetiser to the UART transmitter.
interface match_result_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/match_result_tx.sv
// Turns a MATCH/NOT_MATCH send command plus coordinate into a 7-byte packet
// (sync, status, X, Y, XOR checksum) on a valid/ready byte link.
module match_result_tx #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         X_W       = 10,
   parameter int         Y_W       = 9
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          send_cmd,
   input  logic [X_W-1:0]      x_in,
   input  logic [Y_W-1:0]      y_in,
   match_result_tx_if.master   tx,
   output logic                send_complete,
   output logic                busy,
   output logic [7:0]          pkt_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]  state;
   logic [2:0]  idx;
   logic [1:0]  status;
   logic [15:0] x_lat;
   logic [15:0] y_lat;
   logic [7:0]  byte_sel;

   function automatic logic [7:0] checksum(input logic [1:0] st,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
      return {6'b0, st} ^ x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
   endfunction

   always_comb begin
      byte_sel = 8'h00;
      case (idx)
         3'd0:    byte_sel = SYNC_BYTE;
         3'd1:    byte_sel = {6'b0, status};
         3'd2:    byte_sel = x_lat[15:8];
         3'd3:    byte_sel = x_lat[7:0];
         3'd4:    byte_sel = y_lat[15:8];
         3'd5:    byte_sel = y_lat[7:0];
         3'd6:    byte_sel = checksum(status, x_lat, y_lat);
         default: byte_sel = 8'h00;
      endcase
   end

   assign tx.tx_valid = (state == SEND);
   assign tx.tx_data  = (state == SEND) ? byte_sel : 8'h00;
   assign busy        = (state != IDLE);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         idx           <= 3'd0;
         status        <= 2'd0;
         x_lat         <= 16'd0;
         y_lat         <= 16'd0;
         send_complete <= 1'b0;
         pkt_count     <= 8'd0;
      end else begin
         send_complete <= 1'b0;
         case (state)
            IDLE: begin
               if (send_cmd == 2'd1 || send_cmd == 2'd2) begin
                  status <= send_cmd;
                  // NOT_MATCH reports a zero coordinate regardless of inputs
                  x_lat  <= (send_cmd == 2'd2) ? 16'd0 : 16'(x_in);
                  y_lat  <= (send_cmd == 2'd2) ? 16'd0 : 16'(y_in);
                  idx    <= 3'd0;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (tx.tx_ready) begin
                  if (idx == 3'd6) begin
                     idx           <= 3'd0;
                     send_complete <= 1'b1;
                     pkt_count     <= pkt_count + 8'd1;
                     state         <= RELEASE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            RELEASE: begin
               // a command held by the control unit must not retrigger
               if (send_cmd == 2'd0 || send_cmd == 2'd3)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_match_result_tx.sv
// Scoreboard bench for match_result_tx: stimulus pushes expected bytes, a
// negedge monitor pops and compares on every accepted handshake.
module tb_match_result_tx;

   logic       clock;
   logic       reset;
   logic [1:0] send_cmd;
   logic [9:0] x_in;
   logic [8:0] y_in;
   logic       send_complete;
   logic       busy;
   logic [7:0] pkt_count;

   match_result_tx_if tx_if ();

   match_result_tx #(.SYNC_BYTE(8'hA5), .X_W(10), .Y_W(9)) dut (
      .clock         (clock),
      .reset         (reset),
      .send_cmd      (send_cmd),
      .x_in          (x_in),
      .y_in          (y_in),
      .tx            (tx_if),
      .send_complete (send_complete),
      .busy          (busy),
      .pkt_count     (pkt_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests;
   int failed;
   int hs_count;
   int cpl_count;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares accepted bytes and checks stability under backpressure
   logic       prev_stall;
   logic [7:0] prev_data;
   initial begin
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clock);
         if (reset && prev_stall) begin
            chk("stall_valid_held", 32'(tx_if.tx_valid), 32'd1);
            chk("stall_data_held", 32'(tx_if.tx_data), 32'(prev_data));
         end
         if (reset && tx_if.tx_valid && tx_if.tx_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(tx_if.tx_data), 32'hFFFF_FFFF);
            end else begin
               chk("pkt_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
            end
         end
         if (reset && send_complete) cpl_count++;
         prev_stall = reset && tx_if.tx_valid && !tx_if.tx_ready;
         prev_data  = tx_if.tx_data;
      end
   end

   function automatic logic [55:0] mk(input logic [1:0] c, input logic [9:0] x, input logic [8:0] y);
      logic [15:0] xx, yy;
      logic [7:0]  b1;
      xx = (c == 2'd2) ? 16'd0 : {6'd0, x};
      yy = (c == 2'd2) ? 16'd0 : {7'd0, y};
      b1 = {6'd0, c};
      return {8'hA5, b1, xx[15:8], xx[7:0], yy[15:8], yy[7:0],
              b1 ^ xx[15:8] ^ xx[7:0] ^ yy[15:8] ^ yy[7:0]};
   endfunction

   task automatic push_pkt(input logic [55:0] p);
      for (int i = 6; i >= 0; i--) exp_q.push_back(p[i*8 +: 8]);
   endtask

   // Issues a packet and waits (bounded) for its completion pulse.
   task automatic run_pkt(input logic [1:0] c, input logic [9:0] x, input logic [8:0] y,
                          input logic [55:0] p, input int duty, input bit drop);
      int c0, h0, n;
      c0 = cpl_count;
      h0 = hs_count;
      push_pkt(p);
      @(posedge clock); #1;
      send_cmd = c; x_in = x; y_in = y;
      n = 0;
      while (cpl_count == c0 && n < 400) begin
         @(posedge clock); #1;
         tx_if.tx_ready = ($urandom_range(0, 99) < duty);
         if (n == 3) begin x_in = ~x; y_in = ~y; end
         n++;
      end
      chk("pkt_completed", 32'(cpl_count - c0), 32'd1);
      chk("pkt_handshakes", 32'(hs_count - h0), 32'd7);
      tx_if.tx_ready = 1'b1;
      if (drop) begin
         send_cmd = 2'd0;
         repeat (2) @(posedge clock);
         #1;
      end
   endtask

   initial begin
      int h0, c0;
      tests = 0; failed = 0; hs_count = 0; cpl_count = 0;
      reset = 1'b0; send_cmd = 2'd1; x_in = 10'h13A; y_in = 9'h0F0;
      tx_if.tx_ready = 1'b1;

      // Reset held with a live command
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_cpl", 32'(send_complete), 32'd0);
      end
      chk("rst_count", 32'(pkt_count), 32'd0);
      chk("rst_data", 32'(tx_if.tx_data), 32'd0);
      send_cmd = 2'd0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // MATCH at full rate with exact timing
      push_pkt({8'hA5, 8'h01, 8'h01, 8'h3A, 8'h00, 8'hF0, 8'hCA});
      send_cmd = 2'd1; x_in = 10'h13A; y_in = 9'h0F0;
      @(negedge clock);
      chk("latency_not_early", 32'(tx_if.tx_valid), 32'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         chk("b2b_valid", 32'(tx_if.tx_valid), 32'd1);
      end
      @(negedge clock);
      chk("t2_cpl", 32'(send_complete), 32'd1);
      chk("t2_count", 32'(pkt_count), 32'd1);
      chk("t2_valid_off", 32'(tx_if.tx_valid), 32'd0);
      @(negedge clock);
      chk("t2_cpl_pulse", 32'(send_complete), 32'd0);
      @(posedge clock); #1;
      send_cmd = 2'd0;
      repeat (2) @(posedge clock);
      #1;

      // NOT_MATCH ignores coordinates
      run_pkt(2'd2, 10'h3FF, 9'h1FF, {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02}, 100, 1'b1);
      chk("t3_count", 32'(pkt_count), 32'd2);

      // Backpressure
      run_pkt(2'd1, 10'h3FF, 9'h1FF, {8'hA5, 8'h01, 8'h03, 8'hFF, 8'h01, 8'hFF, 8'h03}, 40, 1'b1);
      chk("t4_count", 32'(pkt_count), 32'd3);

      // Held command produces a single packet
      run_pkt(2'd1, 10'h001, 9'h002, {8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02}, 100, 1'b0);
      h0 = hs_count;
      repeat (20) @(posedge clock);
      #1;
      chk("held_no_retrigger", 32'(hs_count - h0), 32'd0);
      chk("held_busy", 32'(busy), 32'd1);
      chk("held_count", 32'(pkt_count), 32'd4);
      send_cmd = 2'd0;
      @(negedge clock);
      @(negedge clock);
      chk("release_idle", 32'(busy), 32'd0);
      run_pkt(2'd2, 10'h155, 9'h0AA, {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02}, 100, 1'b1);
      chk("t5_count", 32'(pkt_count), 32'd5);
      h0 = hs_count;
      send_cmd = 2'd3;
      repeat (10) @(negedge clock);
      chk("cmd3_no_pkt", 32'(hs_count - h0), 32'd0);
      chk("cmd3_busy", 32'(busy), 32'd0);
      send_cmd = 2'd0;
      @(posedge clock); #1;

      // Reset after b3 accepted aborts the packet
      h0 = hs_count; c0 = cpl_count;
      push_pkt(mk(2'd1, 10'h13A, 9'h0F0));
      send_cmd = 2'd1; x_in = 10'h13A; y_in = 9'h0F0;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("abort_valid", 32'(tx_if.tx_valid), 32'd0);
      chk("abort_count", 32'(pkt_count), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hs", 32'(hs_count - h0), 32'd4);
      @(posedge clock); #1;
      send_cmd = 2'd0;
      exp_q.delete();
      reset = 1'b1;
      repeat (4) @(negedge clock);
      chk("abort_no_cpl", 32'(cpl_count - c0), 32'd0);
      @(posedge clock); #1;

      // Packet counter wrap
      for (int i = 0; i < 256; i++) begin
         logic [1:0] c;
         logic [9:0] x;
         logic [8:0] y;
         c = (i % 3 == 0) ? 2'd2 : 2'd1;
         x = 10'(i * 7);
         y = 9'(i * 3 + 1);
         run_pkt(c, x, y, mk(c, x, y), 100, 1'b1);
         if (i == 254) chk("count_255", 32'(pkt_count), 32'd255);
      end
      chk("count_wrap", 32'(pkt_count), 32'd0);

      repeat (3) @(posedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
